// File: rtl/alu_uart_interface.sv
// alu_uart_interface: sequences three received UART bytes (operand A,
// operand B, opcode) into registered ALU inputs, captures the combinational
// ALU result, and hands it to the UART transmitter with a one-cycle start
// pulse. The block then waits for the transmitter to finish.
module alu_uart_interface #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic                 i_rx_done_tick,
    input  logic                 i_tx_done_tick,
    input  logic [DATA_BITS-1:0] i_alu_result,
    output logic [DATA_BITS-1:0] o_alu_a,
    output logic [DATA_BITS-1:0] o_alu_b,
    output logic [OP_BITS-1:0]   o_alu_op,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        ST_A       = 3'd0,
        ST_B       = 3'd1,
        ST_OP      = 3'd2,
        ST_CALC    = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] alu_a_q, alu_a_d;
    logic [DATA_BITS-1:0] alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]   alu_op_q, alu_op_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;

    // State and datapath registers; reset clears everything so an
    // in-flight transaction is abandoned without a start pulse.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Next-state and register-load decode. Received bytes only matter in
    // the three capture states; tx-done only matters while waiting on tx.
    // The start pulse is registered on the CALC->START transition so it is
    // high exactly while the FSM sits in ST_START.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            ST_A: begin
                if (i_rx_done_tick) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (i_rx_done_tick) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                if (i_rx_done_tick) begin
                    // upper received bits beyond the opcode width are dropped
                    alu_op_d = i_rx_data[OP_BITS-1:0];
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // a coincident rx byte is simply not captured here
                if (i_tx_done_tick) begin
                    state_d = ST_A;
                end
            end
            default: begin
                state_d = ST_A;
            end
        endcase
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = (state_q == ST_CALC) || (state_q == ST_START) ||
                        (state_q == ST_WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a small ADD/SUB ALU model.
module tb_alu_uart_interface;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_tick;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy;

    logic       alu_sub;
    int         n_cmp, n_bad;
    int         pulses, consec;
    logic       start_prev;

    alu_uart_interface #(.DATA_BITS(8), .OP_BITS(6)) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_done_tick (rx_tick),
        .i_tx_done_tick (tx_done),
        .i_alu_result   (alu_result),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational ALU model
    assign alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

    // count start pulses and back-to-back start cycles
    always @(posedge clk) begin
        if (tx_start) pulses++;
        if (tx_start && start_prev) consec++;
        start_prev = tx_start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_tick = 1'b1;
        @(posedge clk); #1;
        rx_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"},     {24'd0, alu_a},   32'h0);
        chk({tag, "_b"},     {24'd0, alu_b},   32'h0);
        chk({tag, "_op"},    {26'd0, alu_op},  32'h0);
        chk({tag, "_txd"},   {24'd0, tx_data}, 32'h0);
        chk({tag, "_start"}, {31'd0, tx_start}, 32'h0);
        chk({tag, "_busy"},  {31'd0, busy},    32'h0);
    endtask

    // full transaction up to ST_WAIT_TX (no tx_done issued)
    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [5:0] exp_op,
                           input logic [7:0] exp_res);
        int base;
        base = pulses;
        send_rx(a);
        chk({tag, "_a"}, {24'd0, alu_a}, {24'd0, a});
        chk({tag, "_busyA"}, {31'd0, busy}, 32'd0);
        send_rx(b);
        chk({tag, "_b"}, {24'd0, alu_b}, {24'd0, b});
        send_rx(op);
        chk({tag, "_op"}, {26'd0, alu_op}, {26'd0, exp_op});
        chk({tag, "_busyC"}, {31'd0, busy}, 32'd1);
        chk({tag, "_start0"}, {31'd0, tx_start}, 32'd0);
        step();
        chk({tag, "_start1"}, {31'd0, tx_start}, 32'd1);
        chk({tag, "_txd"}, {24'd0, tx_data}, {24'd0, exp_res});
        step();
        chk({tag, "_start2"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_busyW"}, {31'd0, busy}, 32'd1);
        chk({tag, "_pulses"}, pulses - base, 32'd1);
    endtask

    initial begin
        int base;
        n_cmp = 0; n_bad = 0; pulses = 0; consec = 0; start_prev = 1'b0;
        rst_n = 1'b0; rx_data = 8'h00; rx_tick = 1'b0; tx_done = 1'b0;
        alu_sub = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;

        // ADD: 5 + 3
        run_txn("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        pulse_tx_done();
        chk("add_done_busy", {31'd0, busy}, 32'd0);

        // opcode masking with SUB: 0x10 - 0x01
        alu_sub = 1'b1;
        run_txn("mask", 8'h10, 8'h01, 8'hE2, 6'h22, 8'h0F);

        // bytes received while busy are dropped
        repeat (3) send_rx(8'hAA);
        chk("drop_a",   {24'd0, alu_a},   32'h10);
        chk("drop_b",   {24'd0, alu_b},   32'h01);
        chk("drop_op",  {26'd0, alu_op},  32'h22);
        chk("drop_txd", {24'd0, tx_data}, 32'h0F);
        chk("drop_busy", {31'd0, busy},   32'd1);
        pulse_tx_done();
        chk("drop_idle", {31'd0, busy}, 32'd0);

        // next byte is operand A again
        alu_sub = 1'b0;
        run_txn("next", 8'h07, 8'h02, 8'h00, 6'h00, 8'h09);

        // rx tick coincident with tx done in ST_WAIT_TX
        @(posedge clk); #1;
        rx_data = 8'h55; rx_tick = 1'b1; tx_done = 1'b1;
        @(posedge clk); #1;
        rx_tick = 1'b0; tx_done = 1'b0;
        chk("sim_busy", {31'd0, busy}, 32'd0);
        chk("sim_a", {24'd0, alu_a}, 32'h07);

        // stray tx done in ST_A
        pulse_tx_done();
        chk("strayA_busy", {31'd0, busy}, 32'd0);
        chk("strayA_a", {24'd0, alu_a}, 32'h07);
        run_txn("postsim", 8'h11, 8'h04, 8'h01, 6'h01, 8'h15);
        pulse_tx_done();

        // stray tx done in ST_B, then reset in ST_OP
        send_rx(8'h05);
        pulse_tx_done();
        chk("strayB_busy", {31'd0, busy}, 32'd0);
        send_rx(8'h03);
        chk("strayB_b", {24'd0, alu_b}, 32'h03);
        chk("strayB_a", {24'd0, alu_a}, 32'h05);
        base = pulses;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (4) step();
        chk("midrst_nopulse", pulses - base, 32'd0);
        chk_all_zero("midrst_hold");
        rst_n = 1'b1;
        repeat (2) step();
        chk("postrst_nopulse", pulses - base, 32'd0);

        run_txn("afterrst", 8'h09, 8'h06, 8'h2A, 6'h2A, 8'h0F);
        pulse_tx_done();
        chk("afterrst_busy", {31'd0, busy}, 32'd0);

        chk("no_consec_start", consec, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
